// File: rtl/apu_fpu_responder_pkg.sv
// Shared types and constants for the FPU-side APU responder.
package apu_fpu_responder_pkg;

  localparam int C_CMD     = 4;
  localparam int C_RM      = 3;
  localparam int C_FFLAG   = 5;
  localparam int C_APU_TAG = 5;

  // fflags bit positions, packed as {NV,DZ,OF,UF,NX}
  localparam int FFLAG_NV = 4;
  localparam int FFLAG_DZ = 3;
  localparam int FFLAG_OF = 2;
  localparam int FFLAG_UF = 1;
  localparam int FFLAG_NX = 0;

  localparam logic [C_FFLAG-1:0] FFLAGS_INVALID = C_FFLAG'(1) << FFLAG_NV;

  localparam logic [C_CMD-1:0] C_FPU_ADD_CMD    = 4'h0;
  localparam logic [C_CMD-1:0] C_FPU_SUB_CMD    = 4'h1;
  localparam logic [C_CMD-1:0] C_FPU_MUL_CMD    = 4'h2;
  localparam logic [C_CMD-1:0] C_FPU_DIV_CMD    = 4'h3;
  localparam logic [C_CMD-1:0] C_FPU_I2F_CMD    = 4'h4;
  localparam logic [C_CMD-1:0] C_FPU_F2I_CMD    = 4'h5;
  localparam logic [C_CMD-1:0] C_FPU_SQRT_CMD   = 4'h6;
  localparam logic [C_CMD-1:0] C_FPU_NOP_CMD    = 4'h7;
  localparam logic [C_CMD-1:0] C_FPU_FMADD_CMD  = 4'h8;
  localparam logic [C_CMD-1:0] C_FPU_FMSUB_CMD  = 4'h9;
  localparam logic [C_CMD-1:0] C_FPU_FNMADD_CMD = 4'hA;
  localparam logic [C_CMD-1:0] C_FPU_FNMSUB_CMD = 4'hB;

  localparam logic [C_RM-1:0] C_RM_MAX_LEGAL = 3'd3;

  typedef enum logic [1:0] {
    KIND_LEGAL   = 2'd0,
    KIND_NOP     = 2'd1,
    KIND_ILLEGAL = 2'd2
  } op_kind_e;

  // Opcodes above FNMSUB and the reserved rounding modes both count as illegal.
  function automatic op_kind_e classify_op(input logic [C_CMD-1:0] op,
                                           input logic [C_RM-1:0]  rm);
    if (rm > C_RM_MAX_LEGAL || op > C_FPU_FNMSUB_CMD) return KIND_ILLEGAL;
    if (op == C_FPU_NOP_CMD) return KIND_NOP;
    return KIND_LEGAL;
  endfunction

endpackage

// File: rtl/apu_fpu_responder_result_fifo.sv
// In-order result buffer: DEPTH entries, registered write, read data shown
// directly from the head entry (zero while empty).
module apu_result_fifo #(
  parameter int DW    = 42,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage array is not reset; only pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/apu_fpu_responder.sv
// FPU-side responder for the private APU request/result protocol.
// Grants against a credit count, issues legal ops to a fixed-latency
// datapath, and returns every granted op's result in order through a buffer.
module apu_fpu_responder
  import apu_fpu_responder_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int WTAG    = C_APU_TAG,
  parameter int LATENCY = 3,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               apu_req_i,
  output logic               apu_gnt_o,
  input  logic [C_CMD-1:0]   apu_op_i,
  input  logic [C_RM-1:0]    apu_rm_i,
  input  logic [WTAG-1:0]    apu_tag_i,
  input  logic [WIDTH-1:0]   apu_operand_a_i,
  input  logic [WIDTH-1:0]   apu_operand_b_i,
  input  logic [WIDTH-1:0]   apu_operand_c_i,
  output logic               apu_rvalid_o,
  input  logic               apu_rready_i,
  output logic [WIDTH-1:0]   apu_result_o,
  output logic [C_FFLAG-1:0] apu_flags_o,
  output logic [WTAG-1:0]    apu_tag_o,
  output logic               fpu_valid_o,
  output logic [C_CMD-1:0]   fpu_op_o,
  output logic [C_RM-1:0]    fpu_rm_o,
  output logic [WIDTH-1:0]   fpu_operand_a_o,
  output logic [WIDTH-1:0]   fpu_operand_b_o,
  output logic [WIDTH-1:0]   fpu_operand_c_o,
  input  logic [WIDTH-1:0]   fpu_result_i,
  input  logic [C_FFLAG-1:0] fpu_flags_i,
  output logic               busy_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int DW = WIDTH + C_FFLAG + WTAG;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [CW-1:0] cnt;
  logic          pop;
  op_kind_e      req_kind;

  logic          iss_valid;
  logic [WTAG-1:0] iss_tag;
  op_kind_e      iss_kind;

  logic            pipe_v    [LATENCY];
  logic [WTAG-1:0] pipe_tag  [LATENCY];
  op_kind_e        pipe_kind [LATENCY];

  logic          fifo_wr;
  logic [DW-1:0] fifo_wdata;
  logic [DW-1:0] fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  // Credit is taken from the registered count, so a pop only frees a slot
  // one cycle later. Reset forces the grant low immediately.
  assign req_kind  = classify_op(apu_op_i, apu_rm_i);
  assign apu_gnt_o = apu_req_i & ~rst & (cnt < DEPTH_C);
  assign pop       = apu_rvalid_o & apu_rready_i;
  assign busy_o    = (cnt != '0);

  // Outstanding-op counter: every granted op holds one buffer slot until popped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      case ({apu_gnt_o, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Issue stage: tracks every grant, but only legal ops reach the datapath;
  // the fpu_* payload keeps its previous value otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_valid       <= 1'b0;
      iss_tag         <= '0;
      iss_kind        <= KIND_LEGAL;
      fpu_valid_o     <= 1'b0;
      fpu_op_o        <= '0;
      fpu_rm_o        <= '0;
      fpu_operand_a_o <= '0;
      fpu_operand_b_o <= '0;
      fpu_operand_c_o <= '0;
    end else begin
      iss_valid   <= apu_gnt_o;
      fpu_valid_o <= apu_gnt_o & (req_kind == KIND_LEGAL);
      if (apu_gnt_o) begin
        iss_tag  <= apu_tag_i;
        iss_kind <= req_kind;
      end
      if (apu_gnt_o && req_kind == KIND_LEGAL) begin
        fpu_op_o        <= apu_op_i;
        fpu_rm_o        <= apu_rm_i;
        fpu_operand_a_o <= apu_operand_a_i;
        fpu_operand_b_o <= apu_operand_b_i;
        fpu_operand_c_o <= apu_operand_c_i;
      end
    end
  end

  // Tracking pipe mirrors the datapath latency and never stalls; clearing
  // its valids on reset discards any result still in the datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_v[i]    <= 1'b0;
        pipe_tag[i]  <= '0;
        pipe_kind[i] <= KIND_LEGAL;
      end
    end else begin
      pipe_v[0]    <= iss_valid;
      pipe_tag[0]  <= iss_tag;
      pipe_kind[0] <= iss_kind;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_v[i]    <= pipe_v[i-1];
        pipe_tag[i]  <= pipe_tag[i-1];
        pipe_kind[i] <= pipe_kind[i-1];
      end
    end
  end

  // Buffer entry at pipe exit: datapath output for legal ops, synthesised
  // zero result for NOPs and invalid-operation flag for illegal commands.
  always_comb begin
    fifo_wdata = '0;
    case (pipe_kind[LATENCY-1])
      KIND_LEGAL: fifo_wdata = {fpu_result_i, fpu_flags_i, pipe_tag[LATENCY-1]};
      KIND_NOP:   fifo_wdata = {{WIDTH{1'b0}}, {C_FFLAG{1'b0}}, pipe_tag[LATENCY-1]};
      default:    fifo_wdata = {{WIDTH{1'b0}}, FFLAGS_INVALID, pipe_tag[LATENCY-1]};
    endcase
  end

  assign fifo_wr = pipe_v[LATENCY-1];

  apu_result_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_result_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_wr),
    .wr_data (fifo_wdata),
    .rd_en   (pop),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign apu_rvalid_o = ~fifo_empty;
  assign {apu_result_o, apu_flags_o, apu_tag_o} = fifo_rdata;

  a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(fifo_wr && fifo_full));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && fifo_empty));
  a_credit_cover: assert property (@(posedge clk) disable iff (rst) cnt >= fifo_count);

endmodule

// File: tb/tb_apu_fpu_responder.sv
// Scoreboard bench for apu_fpu_responder with a fixed-latency datapath stub.
module tb_apu_fpu_responder;
  import apu_fpu_responder_pkg::*;

  localparam int WIDTH   = 32;
  localparam int WTAG    = 5;
  localparam int LATENCY = 3;
  localparam int DEPTH   = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               apu_req_i;
  logic               apu_gnt_o;
  logic [C_CMD-1:0]   apu_op_i;
  logic [C_RM-1:0]    apu_rm_i;
  logic [WTAG-1:0]    apu_tag_i;
  logic [WIDTH-1:0]   apu_operand_a_i, apu_operand_b_i, apu_operand_c_i;
  logic               apu_rvalid_o;
  logic               apu_rready_i;
  logic [WIDTH-1:0]   apu_result_o;
  logic [C_FFLAG-1:0] apu_flags_o;
  logic [WTAG-1:0]    apu_tag_o;
  logic               fpu_valid_o;
  logic [C_CMD-1:0]   fpu_op_o;
  logic [C_RM-1:0]    fpu_rm_o;
  logic [WIDTH-1:0]   fpu_operand_a_o, fpu_operand_b_o, fpu_operand_c_o;
  logic [WIDTH-1:0]   fpu_result_i;
  logic [C_FFLAG-1:0] fpu_flags_i;
  logic               busy_o;

  always #5 clk = ~clk;

  apu_fpu_responder #(
    .WIDTH(WIDTH), .WTAG(WTAG), .LATENCY(LATENCY), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .apu_req_i(apu_req_i), .apu_gnt_o(apu_gnt_o),
    .apu_op_i(apu_op_i), .apu_rm_i(apu_rm_i), .apu_tag_i(apu_tag_i),
    .apu_operand_a_i(apu_operand_a_i), .apu_operand_b_i(apu_operand_b_i),
    .apu_operand_c_i(apu_operand_c_i),
    .apu_rvalid_o(apu_rvalid_o), .apu_rready_i(apu_rready_i),
    .apu_result_o(apu_result_o), .apu_flags_o(apu_flags_o), .apu_tag_o(apu_tag_o),
    .fpu_valid_o(fpu_valid_o), .fpu_op_o(fpu_op_o), .fpu_rm_o(fpu_rm_o),
    .fpu_operand_a_o(fpu_operand_a_o), .fpu_operand_b_o(fpu_operand_b_o),
    .fpu_operand_c_o(fpu_operand_c_o),
    .fpu_result_i(fpu_result_i), .fpu_flags_i(fpu_flags_i),
    .busy_o(busy_o)
  );

  // Datapath stand-in: arbitrary but deterministic result/flags per op.
  function automatic logic [31:0] dp_res(input logic [3:0] op, input logic [31:0] a, b, c);
    if (op == 4'h0 && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    return a ^ {b[15:0], b[31:16]} ^ c ^ {28'h0, op};
  endfunction

  function automatic logic [4:0] dp_flags(input logic [3:0] op, input logic [31:0] a, b);
    return a[4:0] ^ b[9:5] ^ {1'b0, op};
  endfunction

  // Stub pipeline: result appears exactly LATENCY cycles after fpu_valid_o.
  logic [31:0] stub_r [LATENCY];
  logic [4:0]  stub_f [LATENCY];
  always @(posedge clk) begin
    stub_r[0] <= dp_res(fpu_op_o, fpu_operand_a_o, fpu_operand_b_o, fpu_operand_c_o);
    stub_f[0] <= dp_flags(fpu_op_o, fpu_operand_a_o, fpu_operand_b_o);
    for (int i = 1; i < LATENCY; i++) begin
      stub_r[i] <= stub_r[i-1];
      stub_f[i] <= stub_f[i-1];
    end
  end
  assign fpu_result_i = stub_r[LATENCY-1];
  assign fpu_flags_i  = stub_f[LATENCY-1];

  typedef struct { logic [31:0] res; logic [4:0] fl; logic [4:0] tag; } exp_t;
  typedef struct { logic [3:0] op; logic [2:0] rm; logic [31:0] a, b, c; } iss_t;
  exp_t sb[$];
  iss_t iq[$];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: push on grant, check issues and returned results in order.
  always @(negedge clk) begin
    if (!rst) begin
      if (apu_req_i && apu_gnt_o) begin
        exp_t e;
        iss_t s;
        logic ok_rm, ok_legal, ok_nop;
        ok_rm    = (apu_rm_i <= 3'd3);
        ok_legal = ok_rm && (apu_op_i <= 4'h6 || (apu_op_i >= 4'h8 && apu_op_i <= 4'hB));
        ok_nop   = ok_rm && (apu_op_i == 4'h7);
        e.tag = apu_tag_i;
        if (ok_legal) begin
          e.res = dp_res(apu_op_i, apu_operand_a_i, apu_operand_b_i, apu_operand_c_i);
          e.fl  = dp_flags(apu_op_i, apu_operand_a_i, apu_operand_b_i);
          s.op = apu_op_i; s.rm = apu_rm_i;
          s.a = apu_operand_a_i; s.b = apu_operand_b_i; s.c = apu_operand_c_i;
          iq.push_back(s);
        end else if (ok_nop) begin
          e.res = 32'h0; e.fl = 5'b00000;
        end else begin
          e.res = 32'h0; e.fl = 5'b10000;
        end
        sb.push_back(e);
      end
      if (fpu_valid_o) begin
        chk("issue_expected", iq.size() != 0, 1'b1);
        if (iq.size() != 0) begin
          iss_t s;
          s = iq.pop_front();
          chk("issue_op", fpu_op_o, s.op);
          chk("issue_rm", fpu_rm_o, s.rm);
          chk("issue_a", fpu_operand_a_o, s.a);
          chk("issue_b", fpu_operand_b_o, s.b);
          chk("issue_c", fpu_operand_c_o, s.c);
        end
      end
      if (apu_rvalid_o && apu_rready_i) begin
        chk("rsp_expected", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_result", apu_result_o, e.res);
          chk("rsp_flags", apu_flags_o, e.fl);
          chk("rsp_tag", apu_tag_o, e.tag);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [2:0] rm, input logic [4:0] tag,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    apu_req_i = 1'b1; apu_op_i = op; apu_rm_i = rm; apu_tag_i = tag;
    apu_operand_a_i = a; apu_operand_b_i = b; apu_operand_c_i = c;
  endtask

  task automatic drive_rand_legal(input logic [4:0] tag);
    logic [3:0] op;
    op = 4'($urandom_range(0, 10));
    if (op >= 4'h7) op = op + 4'h1;
    drive(op, 3'($urandom_range(0, 3)), tag, $urandom, $urandom, $urandom);
  endtask

  // Caller is in cycle 1 of an op, after its negedge; n is the cycle of first rvalid.
  task automatic wait_rvalid(output int n);
    n = 1;
    while (n < 20) begin
      tick();
      n++;
      @(negedge clk);
      if (apu_rvalid_o) break;
    end
  endtask

  task automatic drain(input string tag);
    apu_req_i = 1'b0;
    apu_rready_i = 1'b1;
    for (int i = 0; i < 60 && busy_o; i++) tick();
    tick();
    chk(tag, busy_o, 1'b0);
  endtask

  int n;

  initial begin
    rst = 1'b1;
    apu_req_i = 1'b0; apu_op_i = '0; apu_rm_i = '0; apu_tag_i = '0;
    apu_operand_a_i = '0; apu_operand_b_i = '0; apu_operand_c_i = '0;
    apu_rready_i = 1'b1;
    repeat (3) tick();
    chk("rst_rvalid", apu_rvalid_o, 1'b0);
    chk("rst_fpu_valid", fpu_valid_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_result", apu_result_o, 32'h0);
    rst = 1'b0;
    tick();

    // Single add
    drive(4'h0, 3'd0, 5'd5, 32'h3F80_0000, 32'h4000_0000, 32'h0);
    @(negedge clk); chk("add_gnt", apu_gnt_o, 1'b1);
    tick(); apu_req_i = 1'b0;
    @(negedge clk);
    chk("add_fpu_valid", fpu_valid_o, 1'b1);
    chk("add_fpu_op", fpu_op_o, 4'h0);
    wait_rvalid(n);
    chk("add_latency", n, LATENCY + 2);
    chk("add_result", apu_result_o, 32'h4040_0000);
    chk("add_tag", apu_tag_o, 5'd5);
    drain("add_drain");

    // Backpressure: only DEPTH grants while nothing is popped
    apu_rready_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive_rand_legal(5'(i));
      @(negedge clk); chk($sformatf("bp_gnt%0d", i), apu_gnt_o, i < DEPTH);
      tick();
    end
    apu_req_i = 1'b0;
    repeat (4) tick();
    apu_rready_i = 1'b1;
    drive_rand_legal(5'd20);
    @(negedge clk); chk("bp_gnt_pop_cycle", apu_gnt_o, 1'b0); chk("bp_rv10", apu_rvalid_o, 1'b1);
    tick();
    @(negedge clk); chk("bp_gnt_after_pop", apu_gnt_o, 1'b1); chk("bp_rv11", apu_rvalid_o, 1'b1);
    tick(); apu_req_i = 1'b0;
    @(negedge clk); chk("bp_rv12", apu_rvalid_o, 1'b1);
    tick();
    @(negedge clk); chk("bp_rv13", apu_rvalid_o, 1'b1);
    drain("bp_drain");

    // Illegal opcode and illegal rounding mode
    drive(4'hD, 3'd0, 5'd2, 32'h1111_1111, 32'h2222_2222, 32'h0);
    @(negedge clk); chk("ill_gnt0", apu_gnt_o, 1'b1);
    tick(); drive(4'h0, 3'b100, 5'd3, 32'h3333_3333, 32'h4444_4444, 32'h0);
    @(negedge clk); chk("ill_gnt1", apu_gnt_o, 1'b1); chk("ill_fv1", fpu_valid_o, 1'b0);
    tick(); apu_req_i = 1'b0;
    @(negedge clk); chk("ill_fv2", fpu_valid_o, 1'b0);
    tick(); tick();
    @(negedge clk); chk("ill_rv4", apu_rvalid_o, 1'b0);
    tick();
    @(negedge clk); chk("ill_rv5", apu_rvalid_o, 1'b1); chk("ill_flags5", apu_flags_o, 5'b10000);
    chk("ill_tag5", apu_tag_o, 5'd2);
    tick();
    @(negedge clk); chk("ill_rv6", apu_rvalid_o, 1'b1); chk("ill_tag6", apu_tag_o, 5'd3);
    tick();
    @(negedge clk); chk("ill_rv7", apu_rvalid_o, 1'b0);
    drain("ill_drain");

    // NOP
    drive(4'h7, 3'd0, 5'd9, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0);
    @(negedge clk); chk("nop_gnt", apu_gnt_o, 1'b1);
    tick(); apu_req_i = 1'b0;
    @(negedge clk); chk("nop_fv", fpu_valid_o, 1'b0);
    wait_rvalid(n);
    chk("nop_latency", n, LATENCY + 2);
    chk("nop_flags", apu_flags_o, 5'b00000);
    drain("nop_drain");

    // Full buffer with simultaneous pop and request
    apu_rready_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive_rand_legal(5'(10 + i));
      @(negedge clk); chk($sformatf("full_gnt%0d", i), apu_gnt_o, 1'b1);
      tick();
    end
    apu_req_i = 1'b0;
    repeat (6) tick();
    chk("full_rvalid", apu_rvalid_o, 1'b1);
    apu_rready_i = 1'b1;
    drive_rand_legal(5'd14);
    @(negedge clk); chk("full_gnt_k", apu_gnt_o, 1'b0);
    tick(); apu_rready_i = 1'b0;
    @(negedge clk); chk("full_gnt_k1", apu_gnt_o, 1'b1);
    tick();
    @(negedge clk); chk("full_gnt_k2", apu_gnt_o, 1'b0);
    drain("full_drain");

    // Reset in flight
    for (int i = 0; i < 3; i++) begin
      drive(4'h2, 3'd1, 5'(1 + i), 32'hA5A5_0000 + i, 32'h0F0F_0F0F, 32'h0);
      @(negedge clk); chk($sformatf("rstf_gnt%0d", i), apu_gnt_o, 1'b1);
      if (i < 2) tick();
    end
    #1 rst = 1'b1;
    #1;
    sb.delete(); iq.delete();
    chk("rstf_gnt", apu_gnt_o, 1'b0);
    chk("rstf_fv", fpu_valid_o, 1'b0);
    chk("rstf_fpu_a", fpu_operand_a_o, 32'h0);
    chk("rstf_busy", busy_o, 1'b0);
    chk("rstf_rvalid", apu_rvalid_o, 1'b0);
    tick(); rst = 1'b0; apu_req_i = 1'b0;
    for (int c = 3; c < 9; c++) begin
      @(negedge clk);
      chk($sformatf("rstf_rv%0d", c), apu_rvalid_o, 1'b0);
      chk($sformatf("rstf_busy%0d", c), busy_o, 1'b0);
      tick();
    end

    // Recovery after reset
    drive(4'h1, 3'd2, 5'd31, 32'h0102_0304, 32'h0506_0708, 32'h090A_0B0C);
    @(negedge clk); chk("rec_gnt", apu_gnt_o, 1'b1);
    tick(); apu_req_i = 1'b0;
    @(negedge clk);
    wait_rvalid(n);
    chk("rec_latency", n, LATENCY + 2);
    drain("rec_drain");

    chk("sb_empty", sb.size(), 0);
    chk("iq_empty", iq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/apu_fpu_responder.md
Name: apu_fpu_responder

Overview:
- Responder (FPU-side) end of the private-FPU APU request/result protocol. The core's ID/EX stage drives this protocol with C_FPU_*_CMD opcodes, C_RM rounding modes and C_FFLAG flags.
- Accepts commands via req/gnt and issues them to an external fixed-latency FP datapath.
- Tracks in-flight tags and buffers results in order. Returns results via rvalid/rready.
- Credit-based granting: results never overflow the buffer.

Parameters:
- WIDTH, 32, operand/result width
- WTAG, 5, tag width (matches C_PC)
- LATENCY, 3, cycles from fpu_valid_o to fpu_result_i valid (>=1)
- DEPTH, 4, result buffer entries = max outstanding ops (power of 2, >=2)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- apu_req_i  in  1  command request
- apu_gnt_o  out  1  command accepted this cycle
- apu_op_i  in  C_CMD  FPU command
- apu_rm_i  in  C_RM  rounding mode
- apu_tag_i  in  WTAG  request tag
- apu_operand_a_i / apu_operand_b_i / apu_operand_c_i  in  WIDTH each  operands
- apu_rvalid_o  out  1  result valid
- apu_rready_i  in  1  core accepts result
- apu_result_o  out  WIDTH  result
- apu_flags_o  out  C_FFLAG  fflags {NV,DZ,OF,UF,NX}
- apu_tag_o  out  WTAG  tag of result
- fpu_valid_o  out  1  issue to datapath
- fpu_op_o  out  C_CMD  issued command
- fpu_rm_o  out  C_RM  issued rounding mode
- fpu_operand_a_o / fpu_operand_b_o / fpu_operand_c_o  out  WIDTH each  issued operands
- fpu_result_i  in  WIDTH  datapath result
- fpu_flags_i  in  C_FFLAG  datapath flags
- busy_o  out  1  any op granted and not yet popped

Behaviour:
- Reset: all outputs 0. Issue register, tracking pipe, buffer and count are cleared.
- Reset mid-operation: in-flight ops are dropped. Datapath results returning after reset are ignored because the tracking-pipe valids are cleared.
- Outstanding count `cnt` (0..DEPTH, registered): +1 on grant, -1 on pop (apu_rvalid_o & apu_rready_i). Both in the same cycle leaves cnt unchanged.
- apu_gnt_o = apu_req_i & (cnt < DEPTH), using the registered cnt. A pop frees credit only in the next cycle. The grant is combinational from req in the same cycle.
- Classification at grant:
  - legal: op in 0x0..0x6 or 0x8..0xB, and rm <= 3.
  - NOP: op = 0x7, with legal rm.
  - Everything else is illegal (op 0xC..0xF, or rm 4..7).
  - Illegal and NOP commands are still granted.
- Issue stage (registered, cycle N+1 for a grant in cycle N):
  - fpu_valid_o = 1 only for legal commands.
  - fpu_* carry the latched op/rm/operands. They hold their last values when fpu_valid_o = 0.
- Tracking pipe: LATENCY-deep shift of {valid, tag, kind}, entered from the issue stage. It advances every cycle and never stalls; the credit scheme guarantees buffer space.
- At the pipe exit (cycle N+1+LATENCY), the buffer is written based on kind:
  - legal: {fpu_result_i, fpu_flags_i, tag}
  - NOP: {0, 5'b00000, tag}
  - illegal: {0, 5'b10000 (NV), tag}
- Result buffer: FIFO of DEPTH entries, registered write.
  - apu_rvalid_o = !empty. First valid result appears at N+2+LATENCY (minimum latency LATENCY+2).
  - Outputs are held stable while apu_rvalid_o & !apu_rready_i.
  - Simultaneous write and pop on a full-minus-one or empty buffer is supported. Pointers wrap modulo DEPTH.
- Ordering: strictly in order; tags are returned as given, never reordered or checked.
- busy_o = (cnt != 0).
- Overflow cannot occur by construction. An assertion checks that a write never happens while full and that a pop never happens while empty.

Decomposition:
- Shared package additions:
  - FFLAG_NV/DZ/OF/UF/NX bit indices.
  - C_APU_TAG = 5.
  - Op-kind enum {KIND_LEGAL, KIND_NOP, KIND_ILLEGAL}.
  - Legality function over C_CMD/C_RM.
- One sub-module: apu_result_fifo, a parameterised WIDTH+C_FFLAG+WTAG wide, DEPTH-entry synchronous FIFO with async active-high reset and full/empty/count outputs.

Test Plan (LATENCY=3, DEPTH=4, datapath stub returning results exactly LATENCY cycles after fpu_valid_o):
- Single add: cycle 0 req op=0x0 rm=0 a=0x3F800000 b=0x40000000 tag=5 -> gnt cycle 0; fpu_valid_o cycle 1 with op=0x0; stub returns 0x40400000 flags 0 at cycle 4; apu_rvalid_o cycle 5, result 0x40400000, tag 5.
- Backpressure: rready=0, 6 back-to-back reqs tags 0..5 -> gnt in cycles 0-3 only, then low. Raise rready at cycle 10 -> results tags 0,1,2,3 on consecutive cycles; gnt reasserts the cycle after the first pop.
- Illegal: op=0xD tag=2, then op=0x0 rm=3'b100 tag=3 -> both granted, fpu_valid_o stays 0; rvalid at cycles 5 and 6 with result 0, flags 5'b10000, tags 2 and 3.
- NOP: op=0x7 rm=0 tag=9 -> granted, no fpu_valid_o; cycle 5 result 0, flags 0, tag 9.
- Full + simultaneous pop/req: cnt=4, rvalid&rready and req high in cycle k -> gnt=0 in k, gnt=1 in k+1; cnt reads 4 again at k+2.
- Reset mid-flight: grants at cycles 0,1,2; rst asserted cycle 2 to 3 -> all outputs 0 immediately; stub results at cycles 4-6 produce no rvalid; busy_o=0 after release.
